// File: rtl/vec_pkg.sv
// Shared definitions for the vector command sequencer: opcodes, FSM states
// and default widths used by the top and its command queue.
package vec_pkg;

    localparam int VEC_DATA_W = 512;
    localparam int VEC_ADDR_W = 2;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_MUL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        WAIT_RD = 2'b10,
        RSP     = 2'b11
    } state_e;

    function automatic logic isReadOp(input logic [1:0] op);
        return op == OP_READ;
    endfunction

endpackage

// File: rtl/vec_cmd_fifo.sv
// Power-of-two command queue with wrapping pointers and an occupancy count.
// The head entry is presented combinationally on rdata.
module vec_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        // A simultaneous push and pop leaves the occupancy unchanged.
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/vec_cmd_sequencer.sv
// Queues vector commands and issues them one at a time to an external
// register file, returning read data through a valid/ready response port.
module vec_cmd_sequencer
    import vec_pkg::*;
#(
    parameter int DATA_W     = VEC_DATA_W,
    parameter int ADDR_W     = VEC_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_raddr,
    input  logic [ADDR_W-1:0] cmd_waddr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [1:0]        rf_op_code,
    output logic [ADDR_W-1:0] rf_read_addr,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    localparam int CMD_W = 2 + 2 * ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [CMD_W-1:0]  issue_q, issue_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [CMD_W-1:0]  fifo_wdata, fifo_head;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic [1:0]        iss_op;
    logic [ADDR_W-1:0] iss_raddr, iss_waddr;
    logic [DATA_W-1:0] iss_wdata;

    assign fifo_wdata = {cmd_op, cmd_raddr, cmd_waddr, cmd_wdata};
    assign fifo_push  = cmd_valid && cmd_ready;
    assign cmd_ready  = !fifo_full;

    vec_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign iss_op    = issue_q[CMD_W-1 -: 2];
    assign iss_raddr = issue_q[DATA_W + ADDR_W +: ADDR_W];
    assign iss_waddr = issue_q[DATA_W +: ADDR_W];
    assign iss_wdata = issue_q[DATA_W-1:0];

    assign rsp_data = rsp_data_q;
    assign busy     = (fifo_count != '0) || (state_q != IDLE);

    // Outside ISSUE the register file sees a harmless read of address 0.
    always_comb begin
        state_d       = state_q;
        issue_d       = issue_q;
        rsp_data_d    = rsp_data_q;
        fifo_pop      = 1'b0;
        rsp_valid     = 1'b0;
        rf_op_code    = OP_READ;
        rf_read_addr  = '0;
        rf_write_addr = '0;
        rf_write_data = '0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    issue_d  = fifo_head;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                rf_op_code    = iss_op;
                rf_read_addr  = iss_raddr;
                rf_write_addr = iss_waddr;
                rf_write_data = iss_wdata;
                state_d       = isReadOp(iss_op) ? WAIT_RD : IDLE;
            end
            WAIT_RD: begin
                rsp_data_d = rf_read_data;
                state_d    = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            issue_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_vec_cmd_sequencer.sv
// Directed bench for vec_cmd_sequencer with a small register-file model that
// answers reads one cycle after the address is presented.
module tb_vec_cmd_sequencer;

    localparam int DATA_W     = 512;
    localparam int ADDR_W     = 2;
    localparam int FIFO_DEPTH = 4;

    localparam logic [1:0] OPW = 2'b00;
    localparam logic [1:0] OPR = 2'b01;
    localparam logic [1:0] OPA = 2'b10;
    localparam logic [1:0] OPM = 2'b11;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_raddr, cmd_waddr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [1:0]        rf_op_code;
    logic [ADDR_W-1:0] rf_read_addr, rf_write_addr;
    logic [DATA_W-1:0] rf_write_data, rf_read_data;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    int passChecks  = 0;
    int totalChecks = 0;

    logic [DATA_W-1:0] regs [4];
    logic              preloadEn = 1'b0;
    logic [ADDR_W-1:0] preloadAddr = '0;
    logic [DATA_W-1:0] preloadData = '0;
    logic [DATA_W-1:0] wrLog [$];
    int                wrCyc [$];
    int                nonReadCount = 0;
    int                cycleCount = 0;

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    vec_cmd_sequencer #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_raddr     (cmd_raddr),
        .cmd_waddr     (cmd_waddr),
        .cmd_wdata     (cmd_wdata),
        .rf_op_code    (rf_op_code),
        .rf_read_addr  (rf_read_addr),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .rf_read_data  (rf_read_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .busy          (busy)
    );

    // ALU ops combine the addressed register with its neighbour.
    always @(posedge clk) begin
        logic [ADDR_W-1:0] nextAddr;
        nextAddr = rf_read_addr + 1'b1;
        cycleCount++;
        rf_read_data <= regs[rf_read_addr];
        if (preloadEn) regs[preloadAddr] <= preloadData;
        else begin
            case (rf_op_code)
                OPW: regs[rf_write_addr] <= rf_write_data;
                OPA: regs[rf_write_addr] <= regs[rf_read_addr] + regs[nextAddr];
                OPM: regs[rf_write_addr] <= regs[rf_read_addr] * regs[nextAddr];
                default: ;
            endcase
        end
        if (rf_op_code != OPR) nonReadCount++;
        if (rf_op_code == OPW) begin
            wrLog.push_back(rf_write_data);
            wrCyc.push_back(cycleCount);
        end
    end

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        totalChecks++;
        if (act === exp) passChecks++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [ADDR_W-1:0] ra,
                                 input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        int waitCnt;
        cmd_op = op; cmd_raddr = ra; cmd_waddr = wa; cmd_wdata = wd;
        cmd_valid = 1'b1;
        waitCnt = 0;
        while (!cmd_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!cmd_ready) checkOutput("cmdAcceptTimeout", DATA_W'(cmd_ready), DATA_W'(1));
        else @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(input string name);
        int waitCnt;
        waitCnt = 0;
        while (!rsp_valid && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput(name, DATA_W'(rsp_valid), DATA_W'(1));
    endtask

    task automatic waitWrites(input int target);
        int waitCnt;
        waitCnt = 0;
        while (wrLog.size() < target && waitCnt < 60) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("writesDrained", DATA_W'(wrLog.size()), DATA_W'(target));
    endtask

    initial begin
        logic [DATA_W-1:0] wide;
        logic              rdy;
        int                base, accepted, nrBase;

        wide = {16{32'hA5C3_0F1E}};
        vecs[0] = '{OPW, 2'd0, 2'd2, DATA_W'(123456), '0};
        vecs[1] = '{OPR, 2'd2, 2'd0, '0, DATA_W'(123456)};
        vecs[2] = '{OPW, 2'd0, 2'd0, DATA_W'(12), '0};
        vecs[3] = '{OPW, 2'd0, 2'd1, DATA_W'(11), '0};
        vecs[4] = '{OPA, 2'd0, 2'd2, '0, '0};
        vecs[5] = '{OPR, 2'd2, 2'd0, '0, DATA_W'(23)};
        vecs[6] = '{OPM, 2'd0, 2'd2, '0, '0};
        vecs[7] = '{OPR, 2'd2, 2'd0, '0, DATA_W'(132)};
        vecs[8] = '{OPW, 2'd0, 2'd3, wide, '0};
        vecs[9] = '{OPR, 2'd3, 2'd0, '0, wide};

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
        cmd_op = OPR; cmd_raddr = '0; cmd_waddr = '0; cmd_wdata = '0;
        preloadEn = 1'b1; preloadAddr = 2'd2; preloadData = DATA_W'(123456);
        repeat (2) @(negedge clk);
        preloadEn = 1'b0;
        checkOutput("rstRspValid", DATA_W'(rsp_valid), '0);
        checkOutput("rstBusy", DATA_W'(busy), '0);
        checkOutput("rstCmdReady", DATA_W'(cmd_ready), DATA_W'(1));
        checkOutput("rstRfOp", DATA_W'(rf_op_code), DATA_W'(OPR));
        checkOutput("rstRfAddrs", DATA_W'({rf_read_addr, rf_write_addr}), '0);
        checkOutput("rstRfWdata", rf_write_data, '0);
        checkOutput("rstRspData", rsp_data, '0);

        // Read offered on the first edge after reset release.
        rst = 1'b0; rsp_ready = 1'b0;
        cmd_op = OPR; cmd_raddr = 2'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("firstAcceptBusy", DATA_W'(busy), DATA_W'(1));
        @(negedge clk);
        checkOutput("issueRfOp", DATA_W'(rf_op_code), DATA_W'(OPR));
        checkOutput("issueRfRaddr", DATA_W'(rf_read_addr), DATA_W'(2));
        @(negedge clk);
        checkOutput("waitRdNoValid", DATA_W'(rsp_valid), '0);
        checkOutput("waitRdIdleAddr", DATA_W'(rf_read_addr), '0);
        @(negedge clk);
        checkOutput("rspValidN3", DATA_W'(rsp_valid), DATA_W'(1));
        checkOutput("rspDataN3", rsp_data, DATA_W'(123456));
        @(negedge clk);
        checkOutput("rspHeld", DATA_W'(rsp_valid), DATA_W'(1));
        checkOutput("rspDataHeld", rsp_data, DATA_W'(123456));
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("rspDone", DATA_W'(rsp_valid), '0);
        checkOutput("idleAfterRsp", DATA_W'(busy), '0);

        base = wrLog.size();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].ra, vecs[i].wa, vecs[i].wd);
            if (vecs[i].op == OPR) begin
                waitRsp($sformatf("vec%0dValid", i));
                checkOutput($sformatf("vec%0dData", i), rsp_data, vecs[i].exp);
                @(negedge clk);
            end
        end
        checkOutput("tableWriteIssues", DATA_W'(wrLog.size() - base), DATA_W'(4));
        checkOutput("tableFirstWdata", wrLog[base], DATA_W'(123456));

        // Stalled response while the queue fills behind it.
        rsp_ready = 1'b0;
        base = wrLog.size();
        applyStimulus(OPR, 2'd2, 2'd0, '0);
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            rdy = cmd_ready;
            if (accepted < 5) begin
                cmd_op = OPW; cmd_waddr = 2'd1; cmd_wdata = DATA_W'(100 + accepted);
                cmd_valid = 1'b1;
            end else cmd_valid = 1'b0;
            @(negedge clk);
            if (cmd_valid && rdy) accepted++;
        end
        cmd_valid = 1'b0;
        checkOutput("bpAccepted", DATA_W'(accepted), DATA_W'(4));
        checkOutput("bpCmdReadyLow", DATA_W'(cmd_ready), '0);
        checkOutput("bpRspValid", DATA_W'(rsp_valid), DATA_W'(1));
        checkOutput("bpRspData", rsp_data, DATA_W'(132));
        checkOutput("bpNoWrites", DATA_W'(wrLog.size() - base), '0);
        rsp_ready = 1'b1;
        waitWrites(base + 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("bpOrder%0d", i), wrLog[base + i], DATA_W'(100 + i));
        checkOutput("bpBackToBack", DATA_W'(wrCyc[base + 1] - wrCyc[base]), DATA_W'(2));
        repeat (2) @(negedge clk);

        // Reset while a read waits for data and three commands sit queued.
        rsp_ready = 1'b0;
        applyStimulus(OPR, 2'd2, 2'd0, '0);
        waitRsp("midRst1Valid");
        applyStimulus(OPR, 2'd2, 2'd0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(OPW, 2'd0, 2'd3, DATA_W'(32'h77 + i));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("midRstIssueAddr", DATA_W'(rf_read_addr), DATA_W'(2));
        @(negedge clk);
        rst = 1'b1;
        #1;
        nrBase = nonReadCount;
        checkOutput("midRstRspValid", DATA_W'(rsp_valid), '0);
        checkOutput("midRstBusy", DATA_W'(busy), '0);
        checkOutput("midRstCmdReady", DATA_W'(cmd_ready), DATA_W'(1));
        checkOutput("midRstRspData", rsp_data, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midRstNoIssues", DATA_W'(nonReadCount - nrBase), '0);
        checkOutput("midRstStillIdle", DATA_W'(busy), '0);

        // Fill to full and drain, three times, so the pointers wrap.
        for (int r = 0; r < 3; r++) begin
            rsp_ready = 1'b0;
            base = wrLog.size();
            applyStimulus(OPR, 2'd2, 2'd0, '0);
            waitRsp($sformatf("wrap%0dRspValid", r));
            for (int i = 0; i < 4; i++) begin
                applyStimulus(OPW, 2'd0, 2'd3, DATA_W'(16 * r + i));
                checkOutput($sformatf("wrap%0dReady%0d", r, i), DATA_W'(cmd_ready),
                            (i == 3) ? '0 : DATA_W'(1));
            end
            checkOutput($sformatf("wrap%0dRspData", r), rsp_data, DATA_W'(132));
            rsp_ready = 1'b1;
            waitWrites(base + 4);
            for (int i = 0; i < 4; i++)
                checkOutput($sformatf("wrap%0dOrder%0d", r, i), wrLog[base + i],
                            DATA_W'(16 * r + i));
            repeat (2) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule

// File: doc/vec_cmd_sequencer.md
VEC_CMD_SEQUENCER -- requirements
Module: vec_cmd_sequencer

Interface
REQ-001 The block SHALL expose these parameters: DATA_W, default 512, vector width; ADDR_W, default 2, register address width; FIFO_DEPTH, default 4, command queue entries (power of two).
REQ-002 The block SHALL expose these ports:
 - clk  in  1  sole clock; all state changes on the rising edge.
 - rst  in  1  asynchronous, active-high reset.
 - cmd_valid  in  1  command offered.
 - cmd_ready  out  1  command queue can accept.
 - cmd_op  in  2  00 write, 01 read, 10 ALU add, 11 ALU multiply.
 - cmd_raddr  in  ADDR_W  read address.
 - cmd_waddr  in  ADDR_W  write address.
 - cmd_wdata  in  DATA_W  write data.
 - rf_op_code  out  2  register-file opcode.
 - rf_read_addr  out  ADDR_W  register-file read address.
 - rf_write_addr  out  ADDR_W  register-file write address.
 - rf_write_data  out  DATA_W  register-file write data.
 - rf_read_data  in  DATA_W  register-file read data.
 - rsp_valid  out  1  read response available.
 - rsp_ready  in  1  response consumer accepts.
 - rsp_data  out  DATA_W  read response payload.
 - busy  out  1  queue non-empty or FSM not IDLE.

Function
REQ-003 A command SHALL be enqueued on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL equal "queue not full".
REQ-004 The queue SHALL be FIFO-ordered, with a count of 0..FIFO_DEPTH and wrapping read and write pointers.
REQ-005 Push and pop in the same cycle SHALL leave the count unchanged. A push when full is impossible because cmd_ready is low.
REQ-006 The FSM SHALL have states IDLE, ISSUE, WAIT_RD and RSP.
REQ-007 IDLE SHALL move to ISSUE, popping the queue head into an issue register, on any edge where the queue is non-empty.
REQ-008 ISSUE SHALL last exactly one cycle and drive rf_op_code, the addresses and rf_write_data from the issue register.
REQ-009 From ISSUE, a write or ALU op SHALL go to IDLE and a read op SHALL go to WAIT_RD.
REQ-010 WAIT_RD SHALL last one cycle, capture rf_read_data into rsp_data at its end, and go to RSP.
REQ-011 In RSP, rsp_valid SHALL be high, with rsp_data stable, until rsp_ready is high; that edge SHALL return the FSM to IDLE.
REQ-012 Outside ISSUE, the rf outputs SHALL idle at rf_op_code=01 with rf_read_addr=0, rf_write_addr=0 and rf_write_data=0, because a read is side-effect free.
REQ-013 Only one command SHALL be outstanding at a time; no pop SHALL occur outside IDLE.
REQ-014 A read accepted into an empty queue while IDLE at edge N SHALL issue in cycle N+1, with rsp_valid high from edge N+3.
REQ-015 Back-to-back writes SHALL each take 2 cycles, ISSUE plus IDLE.
REQ-016 Enqueueing SHALL continue while a response is stalled, until the queue is full.
REQ-017 busy SHALL be high whenever the count is nonzero or the state is not IDLE.

Reset
REQ-018 While rst is high, the state SHALL be IDLE, the count and pointers 0, the issue register 0, and rsp_data 0.
REQ-019 While rst is high, outputs SHALL be rsp_valid=0, busy=0, cmd_ready=1, and the rf outputs at their idle values.
REQ-020 Reset asserted mid-operation SHALL discard queued commands and any pending response immediately, with no further rf write or ALU op issued.
REQ-021 The first command after reset release SHALL be accepted on the first rising edge with rst low.

Structure
REQ-022 Package vec_pkg SHALL hold the opcode constants OP_WRITE, OP_READ, OP_ADD and OP_MUL, the FSM state enumeration, and the default DATA_W and ADDR_W.
REQ-023 The command queue SHALL be a sub-module vec_cmd_fifo, parameterised by width and depth, with push, pop, full, empty and count.

Verification
REQ-024 Reset then one read: cmd read raddr=2 at edge N, register file preloaded reg2=123456 -> rf_op_code=01, rf_read_addr=2 in N+1; rsp_valid from N+3 with rsp_data=123456.
REQ-025 Write then read: write waddr=2 wdata=123456, then read raddr=2 -> one ISSUE cycle with op 00 and data 123456; response 123456.
REQ-026 ALU sequence: write reg0=12, write reg1=11, add, read reg2 -> response 23. Then multiply, read reg2 -> response 132.
REQ-027 Backpressure: hold rsp_ready=0 for 10 cycles after a read, pushing 5 writes -> cmd_ready low after 4 accepted, rsp_data stable, no rf op 00 issued until the response handshakes.
REQ-028 Reset mid-operation: assert rst during WAIT_RD with 3 commands queued -> rsp_valid=0, busy=0, count=0 immediately; no op 00/10/11 observed afterwards.
REQ-029 Full and wrap: push 4 and pop 4 repeatedly for 3 rounds -> commands issued in exact order, and cmd_ready toggles only at count=4.
